// File: rtl/vga_scan_ctrl_if.sv
// Scan/pixel bundle between vga_scan_ctrl (master) and the sprite colour mux / VGA pins (slave).
interface vga_scan_ctrl_if;
    logic [15:0] color;
    logic [9:0]  col;
    logic [8:0]  row;
    logic        rdn;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        frame_start;

    // No valid/ready: col/row move on pixel ticks, color is sampled one pixel later.
    modport master (input color, output col, row, rdn, hs, vs, r, g, b, frame_start);
    modport slave  (output color, input col, row, rdn, hs, vs, r, g, b, frame_start);
endinterface

// File: rtl/vga_scan_ctrl.sv
// Raster scan generator and RGB565 pixel sink for 640x480@60 VGA; two-stage pixel pipeline
// keeps RGB, syncs and display enable aligned one pixel behind col/row.
module vga_scan_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int V_TOTAL      = 525
) (
    input  logic            clk,
    input  logic            rst,
    vga_scan_ctrl_if.master bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS_C   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE_C   = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_C  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS_C   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE_C   = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [9:0]    col_q;
    logic [8:0]    row_q;
    logic          vis0_q, hsync0_q, vsync0_q;
    logic          vis_d, hsync_d, vsync_d, frame_end_d;
    logic [3:0]    r_q, g_q, b_q;
    logic          rdn_q, hs_q, vs_q, fs_q;
    logic          pix_tick;
    logic          unused_color;

    assign pix_tick     = (div_q == DIV_LAST);
    assign unused_color = ^{bus.color[11], bus.color[6:5], bus.color[0]};

    always_comb begin
        div_d       = pix_tick ? '0 : div_q + 1'b1;
        h_d         = h_q + 1'b1;
        v_d         = v_q;
        frame_end_d = (h_q == H_LAST_C) && (v_q == V_LAST_C);
        if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
        end
        vis_d   = (h_q < H_VIS_C) && (v_q < V_VIS_C);
        hsync_d = (h_q >= H_SS_C) && (h_q <= H_SE_C);
        vsync_d = (v_q >= V_SS_C) && (v_q <= V_SE_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            vis0_q   <= 1'b0;
            hsync0_q <= 1'b0;
            vsync0_q <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            rdn_q    <= 1'b1;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            div_q <= div_d;
            fs_q  <= 1'b0;
            if (pix_tick) begin
                h_q      <= h_d;
                v_q      <= v_d;
                // Stage 0: publish the coordinate and its flags.
                col_q    <= h_q;
                row_q    <= v_q[8:0];
                vis0_q   <= vis_d;
                hsync0_q <= hsync_d;
                vsync0_q <= vsync_d;
                // Stage 1: color now belongs to the coordinate published last tick.
                r_q      <= vis0_q ? bus.color[15:12] : 4'h0;
                g_q      <= vis0_q ? bus.color[10:7]  : 4'h0;
                b_q      <= vis0_q ? bus.color[4:1]   : 4'h0;
                rdn_q    <= ~vis0_q;
                hs_q     <= ~hsync0_q;
                vs_q     <= ~vsync0_q;
                fs_q     <= frame_end_d;
            end
        end
    end

    assign bus.col         = col_q;
    assign bus.row         = row_q;
    assign bus.rdn         = rdn_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.r           = r_q;
    assign bus.g           = g_q;
    assign bus.b           = b_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: full horizontal timing with a short frame so whole frames fit the run;
// expected outputs come from pixel-count arithmetic on the number of clk edges since reset release.
module tb_vga_scan_ctrl;
    localparam int CLK_DIV  = 2;
    localparam int H_TOTAL  = 800;
    localparam int H_VIS    = 640;
    localparam int HS_FIRST = 656;
    localparam int HS_LAST  = 751;
    localparam int V_VIS    = 4;
    localparam int VS_FIRST = 6;
    localparam int VS_LAST  = 7;
    localparam int V_TOTAL  = 9;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int TGT_COL  = 100;
    localparam int TGT_ROW  = 3;

    logic clk;
    logic rst;
    vga_scan_ctrl_if bus ();

    vga_scan_ctrl #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VIS), .H_SYNC_START(HS_FIRST), .H_SYNC_END(HS_LAST),
        .H_TOTAL(H_TOTAL), .V_VISIBLE(V_VIS), .V_SYNC_START(VS_FIRST), .V_SYNC_END(VS_LAST),
        .V_TOTAL(V_TOTAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int mode = 0;
    int m_col = 0;
    int m_line = 0;
    int e_h = -1;
    int e_v = -1;
    logic [15:0] exp_q[$];
    logic [9:0] e_col;
    logic [8:0] e_row;
    logic       e_rdn, e_hs, e_vs, e_fs;
    logic [3:0] e_r, e_g, e_b;

    task automatic drive_color();
        logic [15:0] c;
        case (mode)
            1: c = (m_col == TGT_COL && m_line == TGT_ROW) ? 16'hF81F : 16'h0000;
            2: c = 16'hFFFF;
            3: c = 16'($urandom_range(0, 65535));
            default: c = 16'h0000;
        endcase
        bus.color = c;
        exp_q.push_back(c);
    endtask

    task automatic model_reset_values();
        e_col = '0; e_row = '0; e_rdn = 1'b1; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
        e_r = '0; e_g = '0; e_b = '0; e_h = -1; e_v = -1;
    endtask

    // Called #1 after a posedge: the next posedge is edge 1 after release.
    task automatic release_reset();
        n = 0; m_col = 0; m_line = 0;
        exp_q.delete();
        model_reset_values();
        drive_color();
        rst = 1'b0;
    endtask

    task automatic step();
        int k;
        int q;
        logic vis;
        logic [15:0] cur;
        @(posedge clk);
        #1;
        n++;
        e_fs = 1'b0;
        if (n % CLK_DIV == 0) begin
            k = n / CLK_DIV;
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            if (k >= 2) begin
                q   = k - 2;
                e_h = q % H_TOTAL;
                e_v = (q / H_TOTAL) % V_TOTAL;
                vis = (e_h < H_VIS) && (e_v < V_VIS);
                e_rdn = !vis;
                e_hs  = !(e_h >= HS_FIRST && e_h <= HS_LAST);
                e_vs  = !(e_v >= VS_FIRST && e_v <= VS_LAST);
                e_r   = vis ? cur[15:12] : 4'h0;
                e_g   = vis ? cur[10:7]  : 4'h0;
                e_b   = vis ? cur[4:1]   : 4'h0;
            end
            q      = k - 1;
            m_col  = q % H_TOTAL;
            m_line = (q / H_TOTAL) % V_TOTAL;
            e_col  = 10'(m_col);
            e_row  = 9'(m_line);
            e_fs   = (k % FRAME == 0);
            drive_color();
        end
    endtask

    task automatic test_reset();
        mode = 0;
        bus.color = 16'h0000;
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (bus.hs !== 1'b1 || bus.vs !== 1'b1 || bus.rdn !== 1'b1 || bus.col !== 10'd0 ||
                bus.row !== 9'd0 || bus.frame_start !== 1'b0 || {bus.r, bus.g, bus.b} !== 12'h000) begin
                fails++;
                $display("FAIL reset_hold: hs=%b vs=%b rdn=%b col=%0d row=%0d fs=%b rgb=%h, need 1 1 1 0 0 0 000",
                         bus.hs, bus.vs, bus.rdn, bus.col, bus.row, bus.frame_start, {bus.r, bus.g, bus.b});
            end
        end
        release_reset();
        for (int i = 1; i <= 2 * CLK_DIV; i++) begin
            step();
            tests++;
            if (bus.col !== e_col || bus.row !== e_row) begin
                fails++;
                $display("FAIL reset_release_col edge %0d: col=%0d row=%0d, need col=%0d row=%0d",
                         i, bus.col, bus.row, e_col, e_row);
            end
        end
        tests++;
        if (bus.col !== 10'd1) begin
            fails++;
            $display("FAIL first_col_one: col=%0d after %0d edges, need 1", bus.col, 2 * CLK_DIV);
        end
    endtask

    task automatic test_line_timing();
        int t_col0_a = -1;
        int t_col0_b = -1;
        int t_fall = -1;
        int t_rise = -1;
        logic [9:0] prev_col;
        logic prev_hs;
        mode = 0;
        prev_col = bus.col;
        prev_hs  = bus.hs;
        for (int i = 0; i < 3 * H_TOTAL * CLK_DIV; i++) begin
            step();
            tests++;
            if (bus.col !== e_col || bus.row !== e_row || bus.hs !== e_hs || bus.vs !== e_vs ||
                bus.rdn !== e_rdn) begin
                fails++;
                $display("FAIL line_scan n=%0d: col=%0d row=%0d hs=%b vs=%b rdn=%b, need %0d %0d %b %b %b",
                         n, bus.col, bus.row, bus.hs, bus.vs, bus.rdn, e_col, e_row, e_hs, e_vs, e_rdn);
            end
            if (prev_col == 10'(H_TOTAL - 1) && bus.col == 10'd0) begin
                if (t_col0_a < 0) t_col0_a = n;
                else if (t_col0_b < 0) t_col0_b = n;
            end
            if (t_col0_a >= 0 && t_fall < 0 && prev_hs == 1'b1 && bus.hs == 1'b0) t_fall = n;
            if (t_fall >= 0 && t_rise < 0 && prev_hs == 1'b0 && bus.hs == 1'b1) t_rise = n;
            prev_col = bus.col;
            prev_hs  = bus.hs;
        end
        tests++;
        if (t_fall - t_col0_a !== 657 * CLK_DIV || t_col0_a < 0 || t_fall < 0) begin
            fails++;
            $display("FAIL hs_fall_offset: %0d clk, need %0d", t_fall - t_col0_a, 657 * CLK_DIV);
        end
        tests++;
        if (t_rise - t_fall !== 96 * CLK_DIV || t_fall < 0 || t_rise < 0) begin
            fails++;
            $display("FAIL hs_low_width: %0d clk, need %0d", t_rise - t_fall, 96 * CLK_DIV);
        end
        tests++;
        if (t_col0_b - t_col0_a !== H_TOTAL * CLK_DIV || t_col0_a < 0 || t_col0_b < 0) begin
            fails++;
            $display("FAIL line_period: %0d clk, need %0d", t_col0_b - t_col0_a, H_TOTAL * CLK_DIV);
        end
    endtask

    task automatic test_color_path();
        int hits = 0;
        mode = 1;
        for (int i = 0; i < FRAME * CLK_DIV; i++) begin
            step();
            tests++;
            if ({bus.r, bus.g, bus.b} !== {e_r, e_g, e_b} || bus.rdn !== e_rdn) begin
                fails++;
                $display("FAIL color_path n=%0d: rgb=%h rdn=%b, need rgb=%h rdn=%b",
                         n, {bus.r, bus.g, bus.b}, bus.rdn, {e_r, e_g, e_b}, e_rdn);
            end
            if (e_h == TGT_COL && e_v == TGT_ROW) begin
                hits++;
                tests++;
                if (bus.r !== 4'hF || bus.g !== 4'h0 || bus.b !== 4'hF || bus.rdn !== 1'b0) begin
                    fails++;
                    $display("FAIL color_target: r=%h g=%h b=%h rdn=%b, need F 0 F 0",
                             bus.r, bus.g, bus.b, bus.rdn);
                end
            end
            if (e_v == TGT_ROW && e_h == TGT_COL + 2) break;
        end
        tests++;
        if (hits !== CLK_DIV) begin
            fails++;
            $display("FAIL color_target_seen: %0d cycles, need %0d", hits, CLK_DIV);
        end
    endtask

    task automatic test_random_color();
        mode = 3;
        for (int i = 0; i < H_TOTAL * CLK_DIV; i++) begin
            step();
            tests++;
            if ({bus.r, bus.g, bus.b} !== {e_r, e_g, e_b} || bus.rdn !== e_rdn) begin
                fails++;
                $display("FAIL random_color n=%0d: rgb=%h rdn=%b, need rgb=%h rdn=%b",
                         n, {bus.r, bus.g, bus.b}, bus.rdn, {e_r, e_g, e_b}, e_rdn);
            end
        end
    endtask

    task automatic test_blanking_frame();
        int t1 = -1;
        int t2 = -1;
        int fs_cnt = 0;
        int vs_low = 0;
        mode = 2;
        for (int i = 0; i < 3 * FRAME * CLK_DIV; i++) begin
            step();
            tests++;
            if (bus.frame_start !== e_fs || bus.vs !== e_vs || bus.rdn !== e_rdn ||
                {bus.r, bus.g, bus.b} !== {e_r, e_g, e_b}) begin
                fails++;
                $display("FAIL blank_frame n=%0d: fs=%b vs=%b rdn=%b rgb=%h, need %b %b %b %h",
                         n, bus.frame_start, bus.vs, bus.rdn, {bus.r, bus.g, bus.b},
                         e_fs, e_vs, e_rdn, {e_r, e_g, e_b});
            end
            if (bus.frame_start === 1'b1) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            if (t1 >= 0 && t2 < 0) begin
                if (bus.frame_start === 1'b1) fs_cnt++;
                if (bus.vs === 1'b0) vs_low++;
            end
            if (t2 >= 0) break;
        end
        tests++;
        if (t2 - t1 !== FRAME * CLK_DIV || t1 < 0 || t2 < 0) begin
            fails++;
            $display("FAIL frame_period: t1=%0d t2=%0d, need spacing %0d", t1, t2, FRAME * CLK_DIV);
        end
        tests++;
        if (fs_cnt !== 1) begin
            fails++;
            $display("FAIL frame_pulse_width: %0d cycles, need 1", fs_cnt);
        end
        tests++;
        if (vs_low !== 2 * H_TOTAL * CLK_DIV) begin
            fails++;
            $display("FAIL vs_low_width: %0d clk, need %0d", vs_low, 2 * H_TOTAL * CLK_DIV);
        end
    endtask

    task automatic test_mid_frame_reset();
        int found = 0;
        int fs_cnt = 0;
        int t_fs = -1;
        mode = 0;
        for (int i = 0; i < FRAME * CLK_DIV; i++) begin
            step();
            if (e_col == 10'd300 && e_row == 9'd2) begin
                found = 1;
                break;
            end
        end
        tests++;
        if (found !== 1 || bus.col !== 10'd300 || bus.row !== 9'd2) begin
            fails++;
            $display("FAIL mid_reset_reach: col=%0d row=%0d, need 300 2", bus.col, bus.row);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.hs !== 1'b1 || bus.vs !== 1'b1 || bus.rdn !== 1'b1 || bus.col !== 10'd0 ||
            bus.row !== 9'd0 || bus.frame_start !== 1'b0 || {bus.r, bus.g, bus.b} !== 12'h000) begin
            fails++;
            $display("FAIL mid_reset_async: hs=%b vs=%b rdn=%b col=%0d row=%0d fs=%b rgb=%h, need 1 1 1 0 0 0 000",
                     bus.hs, bus.vs, bus.rdn, bus.col, bus.row, bus.frame_start, {bus.r, bus.g, bus.b});
        end
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        for (int i = 0; i < FRAME * CLK_DIV + 2 * CLK_DIV; i++) begin
            step();
            tests++;
            if (bus.col !== e_col || bus.row !== e_row || bus.hs !== e_hs || bus.vs !== e_vs ||
                bus.rdn !== e_rdn || bus.frame_start !== e_fs) begin
                fails++;
                $display("FAIL restart_scan n=%0d: col=%0d row=%0d hs=%b vs=%b rdn=%b fs=%b, need %0d %0d %b %b %b %b",
                         n, bus.col, bus.row, bus.hs, bus.vs, bus.rdn, bus.frame_start,
                         e_col, e_row, e_hs, e_vs, e_rdn, e_fs);
            end
            if (bus.frame_start === 1'b1) begin
                fs_cnt++;
                if (t_fs < 0) t_fs = n;
            end
        end
        tests++;
        if (fs_cnt !== 1 || t_fs !== FRAME * CLK_DIV) begin
            fails++;
            $display("FAIL restart_frame_pulse: count=%0d at=%0d, need 1 at %0d", fs_cnt, t_fs, FRAME * CLK_DIV);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.color = 16'h0000;
        model_reset_values();
        test_reset();
        test_line_timing();
        test_color_path();
        test_random_color();
        test_blanking_frame();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
